// File: rtl/sound_pkg.sv
// ============================================================================
// sound_pkg : register map, ENV field layout and phase width shared by the
//             pulse-wave generator top level and its channel engine.
// Revision  : 1.0
// ============================================================================
`default_nettype none

package sound_pkg;

  localparam logic [1:0] REG_PERIOD = 2'd0;
  localparam logic [1:0] REG_SHAPE  = 2'd1;
  localparam logic [1:0] REG_ENV    = 2'd2;
  localparam logic [1:0] REG_GATE   = 2'd3;

  localparam int ENV_RATE_LSB = 0;
  localparam int ENV_RATE_W   = 8;
  localparam int ENV_DIR_BIT  = 8;
  localparam int ENV_EN_BIT   = 9;

  localparam int SHAPE_WIDTH_LSB = 8;
  localparam int GATE_BIT        = 0;
  localparam int PHASE_W         = 3;

endpackage

`default_nettype wire

// File: rtl/sound_channel_env.sv
// ============================================================================
// sound_channel_env : one pulse channel with duty phase, key gate and a
//                     linear volume envelope; emits a VOL_W-bit level.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module sound_channel_env
  import sound_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_addr_i,
  input  logic [15:0]      wr_data_i,
  input  logic             env_tick_i,
  output logic [VOL_W-1:0] level_o,
  output logic             active_o
);

  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [PHASE_W-1:0]    width_q, width_d;
  logic [VOL_W-1:0]      volume_q, volume_d;
  logic [ENV_RATE_W-1:0] rate_q, rate_d;
  logic [ENV_RATE_W-1:0] envcnt_q, envcnt_d;
  logic                  dir_q, dir_d;
  logic                  en_q, en_d;
  logic                  gate_q, gate_d;

  logic wr_period, wr_shape, wr_env, wr_gate, retrigger;
  logic running, env_on, env_step;
  logic [PERIOD_W-1:0] reload_val;
  logic unused_wr_data;

  assign unused_wr_data = ^wr_data_i;

  always_comb begin
    wr_period  = wr_en_i && (wr_addr_i == REG_PERIOD);
    wr_shape   = wr_en_i && (wr_addr_i == REG_SHAPE);
    wr_env     = wr_en_i && (wr_addr_i == REG_ENV);
    wr_gate    = wr_en_i && (wr_addr_i == REG_GATE);
    retrigger  = wr_gate && wr_data_i[GATE_BIT];
    // A PERIOD write landing on a reload cycle takes effect for that reload.
    reload_val = wr_period ? wr_data_i[PERIOD_W-1:0] : period_q;
    running    = gate_q && (period_q != '0);
    env_on     = env_tick_i && en_q && gate_q;
    env_step   = env_on && (envcnt_q == rate_q);

    period_d = wr_period ? wr_data_i[PERIOD_W-1:0] : period_q;
    width_d  = wr_shape ? wr_data_i[SHAPE_WIDTH_LSB +: PHASE_W] : width_q;
    rate_d   = wr_env ? wr_data_i[ENV_RATE_LSB +: ENV_RATE_W] : rate_q;
    dir_d    = wr_env ? wr_data_i[ENV_DIR_BIT] : dir_q;
    en_d     = wr_env ? wr_data_i[ENV_EN_BIT] : en_q;
    gate_d   = wr_gate ? wr_data_i[GATE_BIT] : gate_q;

    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (retrigger) begin
      cnt_d   = period_q;
      phase_d = '0;
    end else if (running) begin
      if (cnt_q == '0) begin
        cnt_d   = reload_val;
        phase_d = phase_q + 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    envcnt_d = envcnt_q;
    if (retrigger || env_step) begin
      envcnt_d = '0;
    end else if (env_on) begin
      envcnt_d = envcnt_q + 1'b1;
    end

    // A SHAPE write outranks an envelope step in the same cycle.
    volume_d = volume_q;
    if (wr_shape) begin
      volume_d = wr_data_i[VOL_W-1:0];
    end else if (env_step) begin
      if (dir_q) begin
        if (volume_q != '1) volume_d = volume_q + 1'b1;
      end else begin
        if (volume_q != '0) volume_d = volume_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_q <= '1;
      cnt_q    <= '1;
      phase_q  <= '0;
      width_q  <= '0;
      volume_q <= '0;
      rate_q   <= '0;
      envcnt_q <= '0;
      dir_q    <= 1'b0;
      en_q     <= 1'b0;
      gate_q   <= 1'b0;
    end else begin
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      width_q  <= width_d;
      volume_q <= volume_d;
      rate_q   <= rate_d;
      envcnt_q <= envcnt_d;
      dir_q    <= dir_d;
      en_q     <= en_d;
      gate_q   <= gate_d;
    end
  end

  assign level_o  = (running && (phase_q <= width_q)) ? volume_q : '0;
  assign active_o = gate_q && (volume_q != '0);

endmodule

`default_nettype wire

// File: rtl/sound_generator_env.sv
// ============================================================================
// sound_generator_env : N-channel pulse generator with envelope; decodes
//                       register writes and mixes levels into one sample.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module sound_generator_env
  import sound_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 16,
  parameter int VOL_W    = 5,
  parameter int SAMPLE_W = 24,
  parameter int ENV_DIV  = 48000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_en_i,
  // One bit wider than the channel index so out-of-range targets exist and are dropped.
  input  logic [$clog2(NUM_CH):0]   wr_ch_i,
  input  logic [1:0]                wr_addr_i,
  input  logic [15:0]               wr_data_i,
  output logic [SAMPLE_W-1:0]       sample_o,
  output logic [NUM_CH-1:0]         ch_active_o
);

  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int SUM_W = VOL_W + $clog2(NUM_CH);
  localparam int SHIFT = SAMPLE_W - SUM_W;
  localparam int DIV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;

  logic [DIV_W-1:0]    presc_q;
  logic                env_tick;
  logic [VOL_W-1:0]    level [NUM_CH];
  logic [NUM_CH-1:0]   active;
  logic [SUM_W-1:0]    sum;
  logic [SAMPLE_W-1:0] sample_q, sample_d;
  logic [NUM_CH-1:0]   active_q;

  assign env_tick = (presc_q == DIV_W'(ENV_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= env_tick ? '0 : presc_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    sound_channel_env #(
      .PERIOD_W (PERIOD_W),
      .VOL_W    (VOL_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en_i && (wr_ch_i == CH_W'(i))),
      .wr_addr_i  (wr_addr_i),
      .wr_data_i  (wr_data_i),
      .env_tick_i (env_tick),
      .level_o    (level[i]),
      .active_o   (active[i])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + SUM_W'(level[i]);
    end
    sample_d = SAMPLE_W'(sum) << SHIFT;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q <= '0;
      active_q <= '0;
    end else begin
      sample_q <= sample_d;
      active_q <= active;
    end
  end

  assign sample_o    = sample_q;
  assign ch_active_o = active_q;

endmodule

`default_nettype wire

// File: tb/tb_sound_generator_env.sv
// ============================================================================
// tb_sound_generator_env : directed stimulus with a queued scoreboard for the
//                          4-channel pulse generator (ENV_DIV = 8).
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_sound_generator_env;
  import sound_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_ch;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [23:0] sample;
  logic [3:0]  ch_active;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        chk;
    logic [23:0] s;
    logic [3:0]  a;
    string       nm;
  } exp_t;

  exp_t q[$];
  exp_t me;

  always #5 clk = ~clk;

  sound_generator_env #(
    .NUM_CH   (4),
    .PERIOD_W (16),
    .VOL_W    (5),
    .SAMPLE_W (24),
    .ENV_DIV  (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (wr_en),
    .wr_ch_i     (wr_ch),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .sample_o    (sample),
    .ch_active_o (ch_active)
  );

  // One expectation per clock edge; the monitor consumes it half a cycle later.
  task automatic cyc(input logic chk, input logic [23:0] s, input logic [3:0] a, input string nm);
    exp_t e;
    @(posedge clk);
    e.chk = chk;
    e.s   = s;
    e.a   = a;
    e.nm  = nm;
    q.push_back(e);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wr_set(input logic [2:0] ch, input logic [1:0] addr, input logic [15:0] data);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_addr = addr;
    wr_data = data;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] addr, input logic [15:0] data);
    wr_set(ch, addr, data);
    cyc(1'b0, 24'h0, 4'h0, "");
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    cyc(1'b1, 24'h0, 4'h0, nm);
    reset = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        me = q.pop_front();
        if (me.chk) begin
          checks++;
          if (sample !== me.s) begin
            errors++;
            $display("FAIL %s sample got %h want %h", me.nm, sample, me.s);
          end
          checks++;
          if (ch_active !== me.a) begin
            errors++;
            $display("FAIL %s ch_active got %b want %b", me.nm, ch_active, me.a);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] v;
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_ch   = '0;
    wr_addr = '0;
    wr_data = '0;

    // 1) single channel, 50% duty: 4 steps of 4 clks high, 4 low
    do_reset("t1_reset");
    wr(3'd0, REG_PERIOD, 16'd3);
    wr(3'd0, REG_SHAPE, 16'h031F);
    wr(3'd0, REG_GATE, 16'h0001);
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'h3E0000, 4'b0001, "t1_hi");
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'h000000, 4'b0001, "t1_lo");
    for (int i = 0; i < 16; i++) cyc(1'b1, 24'h3E0000, 4'b0001, "t1_hi2");

    // 2) all channels at full DC volume
    wr(3'd0, REG_SHAPE, 16'h071F);
    for (int c = 1; c < 4; c++) begin
      wr(3'(c), REG_SHAPE, 16'h071F);
      wr(3'(c), REG_GATE, 16'h0001);
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 24'hF80000, 4'hF, "t2_sum");

    // 6) reset while playing, then gate without rewriting SHAPE
    do_reset("t6_reset");
    wr(3'd0, REG_GATE, 16'h0001);
    for (int i = 0; i < 6; i++) cyc(1'b1, 24'h0, 4'h0, "t6_silent");
    wr(3'd0, REG_SHAPE, 16'h070A);
    for (int i = 0; i < 4; i++) cyc(1'b1, 24'h140000, 4'b0001, "t6_shape");

    // 3) decaying envelope, rate 1: one step per 16 clks, holds at 0
    do_reset("t3_reset");
    wr(3'd0, REG_SHAPE, 16'h0704);
    wr(3'd0, REG_ENV, 16'h0201);
    wr(3'd0, REG_GATE, 16'h0001);
    for (int i = 4; i <= 72; i++) begin
      v = (i <= 16) ? 24'd4 : (i <= 32) ? 24'd3 : (i <= 48) ? 24'd2 : (i <= 64) ? 24'd1 : 24'd0;
      cyc(1'b1, v << 17, (i <= 64) ? 4'b0001 : 4'b0000, "t3_env");
    end

    // 4) period change mid-step takes effect only at the next reload
    do_reset("t4_reset");
    wr(3'd0, REG_PERIOD, 16'd3);
    wr(3'd0, REG_SHAPE, 16'h011F);
    wr(3'd0, REG_GATE, 16'h0001);
    for (int i = 4; i <= 70; i++) begin
      if (i == 5) wr_set(3'd0, REG_PERIOD, 16'd7);
      cyc(1'b1, (i <= 15 || i >= 64) ? 24'h3E0000 : 24'h0, 4'b0001, "t4_period");
    end

    // 5) SHAPE write on an envelope step, then out-of-range channel writes
    do_reset("t5_reset");
    wr(3'd0, REG_SHAPE, 16'h0714);
    wr(3'd0, REG_ENV, 16'h0300);
    wr(3'd0, REG_GATE, 16'h0001);
    for (int i = 4; i <= 48; i++) begin
      if (i == 16) wr_set(3'd0, REG_SHAPE, 16'h070A);
      if (i == 33) wr_set(3'd5, REG_SHAPE, 16'h071F);
      if (i == 34) wr_set(3'd4, REG_SHAPE, 16'h071F);
      v = (i <= 8) ? 24'd20 : (i <= 16) ? 24'd21 : (i <= 24) ? 24'd10 :
          (i <= 32) ? 24'd11 : (i <= 40) ? 24'd12 : 24'd13;
      cyc(1'b1, v << 17, 4'b0001, "t5_wr");
    end

    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain queue got %0d left want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
